// File: rtl/im_pkg.sv
// ---------------------------------------------------------------------------
// im_pkg
// Shared definitions for the synchronous-read instruction memory:
//   - fault codes returned alongside every fetch response
//   - default code-segment base address
//   - response-buffer occupancy states
//   - im_classify(): folds the alignment/range checks into a fault code
// ---------------------------------------------------------------------------
package im_pkg;

  localparam int IM_FAULT_W = 2;

  localparam logic [IM_FAULT_W-1:0] IM_FAULT_OK         = 2'd0;
  localparam logic [IM_FAULT_W-1:0] IM_FAULT_MISALIGNED = 2'd1;
  localparam logic [IM_FAULT_W-1:0] IM_FAULT_RANGE      = 2'd2;

  // Code segment start PC; im[0] lives here.
  localparam logic [15:0] IM_DEFAULT_BASE = 16'h3000;

  // Response buffer occupancy; the encoding equals the entry count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  // Misalignment wins over a range violation.
  function automatic logic [IM_FAULT_W-1:0] im_classify(input logic misaligned,
                                                        input logic in_range);
    logic [IM_FAULT_W-1:0] code;
    code = IM_FAULT_OK;
    if (misaligned) begin
      code = IM_FAULT_MISALIGNED;
    end else if (!in_range) begin
      code = IM_FAULT_RANGE;
    end
    return code;
  endfunction

endpackage

// File: rtl/im_resp_fifo.sv
// ---------------------------------------------------------------------------
// im_resp_fifo
// Two-entry in-order buffer of {data, fault} fetch responses.
//   clk, rst      : clock, synchronous active-high reset (empties the buffer)
//   push          : write push_data/push_fault at this edge (ignored when full)
//   push_data     : response word
//   push_fault    : response fault code
//   pop           : remove the head at this edge (ignored when empty)
//   head_data     : head word, 0 when empty
//   head_fault    : head fault code, 0 when empty
//   full, empty   : occupancy flags, straight from the state register
// ---------------------------------------------------------------------------
module im_resp_fifo
  import im_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [IM_FAULT_W-1:0] push_fault,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [IM_FAULT_W-1:0] head_fault,
  output logic                  full,
  output logic                  empty
);

  localparam int SLOTS = 2;

  buf_state_t state_reg, state_next;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic       push_ok;
  logic       pop_ok;

  logic [DATA_WIDTH-1:0] data_mem  [SLOTS];
  logic [IM_FAULT_W-1:0] fault_mem [SLOTS];

  assign full    = (state_reg == BUF_FULL);
  assign empty   = (state_reg == BUF_EMPTY);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Occupancy: push-only grows, pop-only shrinks, both or neither holds.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      BUF_EMPTY: begin
        if (push_ok) state_next = BUF_ONE;
      end
      BUF_ONE: begin
        if (push_ok && !pop_ok)      state_next = BUF_FULL;
        else if (pop_ok && !push_ok) state_next = BUF_EMPTY;
      end
      BUF_FULL: begin
        if (pop_ok) state_next = BUF_ONE;
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= BUF_EMPTY;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Slot contents need no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_ptr_reg]  <= push_data;
      fault_mem[wr_ptr_reg] <= push_fault;
    end
  end

  assign head_data  = empty ? '0 : data_mem[rd_ptr_reg];
  assign head_fault = empty ? IM_FAULT_OK : fault_mem[rd_ptr_reg];

endmodule

// File: rtl/im_sync_param.sv
// ---------------------------------------------------------------------------
// im_sync_param
// Parametrised instruction memory for the fetch stage. A request accepted at
// edge N is checked, read and pushed into a 2-entry response buffer at that
// same edge, so resp_valid rises one cycle after the request was presented.
// Misaligned and out-of-segment fetches return data 0 with a fault code and
// still occupy a buffer slot, keeping responses in request order.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : fetch request present
//   req_ready   : buffer has room (depends only on registered state)
//   req_addr    : byte address of fetch
//   resp_valid  : head of response buffer valid
//   resp_ready  : consumer takes the head this cycle
//   resp_data   : instruction word, 0 when faulted or empty
//   resp_fault  : 0 OK, 1 misaligned, 2 out of range
// Optional (macro IM_LOAD_PORT_EN):
//   wr_en, wr_addr, wr_data, wr_be : byte-enabled word write; misaligned or
//   out-of-range writes are dropped. A fetch of the same word at the same
//   edge returns the old contents.
// ---------------------------------------------------------------------------
module im_sync_param
  import im_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 8192,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(IM_DEFAULT_BASE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [IM_FAULT_W-1:0] resp_fault
`ifdef IM_LOAD_PORT_EN
  ,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int BYTES = DATA_WIDTH / 8;

  // Segment arithmetic is one bit wider than the address so the end of a
  // segment that touches the top of the address space does not wrap to 0.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] SEG_BYTES = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] im [DEPTH_WORDS];

  // ---------------- fetch address check ----------------
  logic [ADDR_WIDTH:0]   rd_ext;
  logic [ADDR_WIDTH:0]   rd_offset;
  logic                  rd_in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic [IM_FAULT_W-1:0] rd_fault;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  accept;
  logic                  buf_full;
  logic                  buf_empty;

  assign rd_ext    = {1'b0, req_addr};
  assign rd_offset = rd_ext - BASE_EXT;
  // Once addr >= BASE, "offset < segment size" is the same test as
  // "addr < BASE + segment size".
  assign rd_in_range = (rd_ext >= BASE_EXT) && (rd_offset < SEG_BYTES);
  assign rd_idx      = rd_offset[IDX_W+1:2];
  assign rd_fault    = im_classify(|req_addr[1:0], rd_in_range);

  // The array is read at the accept edge straight into the response buffer.
  assign rd_word = (rd_fault == IM_FAULT_OK) ? im[rd_idx] : '0;

  assign req_ready  = ~buf_full;
  assign accept     = req_valid & req_ready;
  assign resp_valid = ~buf_empty;

  im_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_data  (rd_word),
    .push_fault (rd_fault),
    .pop        (resp_ready),
    .head_data  (resp_data),
    .head_fault (resp_fault),
    .full       (buf_full),
    .empty      (buf_empty)
  );

`ifdef IM_LOAD_PORT_EN
  // ---------------- optional load port ----------------
  logic [ADDR_WIDTH:0] wr_ext;
  logic [ADDR_WIDTH:0] wr_offset;
  logic                wr_hit;
  logic [IDX_W-1:0]    wr_idx;

  assign wr_ext    = {1'b0, wr_addr};
  assign wr_offset = wr_ext - BASE_EXT;
  assign wr_hit    = wr_en && (wr_addr[1:0] == 2'b00) &&
                     (wr_ext >= BASE_EXT) && (wr_offset < SEG_BYTES);
  assign wr_idx    = wr_offset[IDX_W+1:2];

  // Non-blocking update: a same-edge fetch still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) im[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end
`endif

endmodule

// File: tb/tb_im_sync_param.sv
module tb_im_sync_param;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  f;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault;
`ifdef IM_LOAD_PORT_EN
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 0;

  logic [31:0] model_mem [8192];
  resp_t       mq[$];    // model response buffer
  resp_t       obs[$];   // responses actually taken from the DUT
  resp_t       m_e;
  bit          m_pop, m_push;

  im_sync_param dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_fault (resp_fault)
`ifdef IM_LOAD_PORT_EN
    ,
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetch result straight from the address rules.
  function automatic resp_t model_fetch(input logic [15:0] a);
    resp_t r;
    int    ia;
    ia  = int'(a);
    r.d = 32'h0;
    r.f = 2'd0;
    if (a[1:0] != 2'b00)                            r.f = 2'd1;
    else if (ia < 'h3000 || ia >= 'h3000 + 4*8192)  r.f = 2'd2;
    else                                            r.d = model_mem[(ia - 'h3000) / 4];
    return r;
  endfunction

  function automatic logic [31:0] preload_word(input int k);
    return 32'h00010203 + 32'(k) * 32'h04040404;
  endfunction

  // Model: a queue of at most two responses.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_pop  = resp_ready && (mq.size() > 0);
      m_push = req_valid && (mq.size() < 2);
      if (m_push) m_e = model_fetch(req_addr);
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(m_e);
`ifdef IM_LOAD_PORT_EN
      if (wr_en && wr_addr[1:0] == 2'b00 && int'(wr_addr) >= 'h3000 &&
          int'(wr_addr) < 'h3000 + 4*8192) begin
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) model_mem[(int'(wr_addr) - 'h3000) / 4][b*8 +: 8] = wr_data[b*8 +: 8];
      end
`endif
    end
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(mq.size() < 2));
      check("resp_valid", 32'(resp_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("resp_data", resp_data, mq[0].d);
        check("resp_fault", 32'(resp_fault), 32'(mq[0].f));
      end else begin
        check("idle_data", resp_data, 32'h0);
        check("idle_fault", 32'(resp_fault), 32'h0);
      end
      if (resp_valid && resp_ready) obs.push_back('{d: resp_data, f: resp_fault});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [15:0] a);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("issue_accept", 32'(req_ready), 32'h1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k;
    int sent[$];
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int sent[$];
    rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0; resp_ready = 1'b0;
`ifdef IM_LOAD_PORT_EN
    wr_en = 1'b0; wr_addr = 16'h0; wr_data = 32'h0; wr_be = 4'h0;
`endif
    for (int i = 0; i < 8192; i++) begin
      model_mem[i] = (i < 10) ? preload_word(i) : (32'hA5000000 | 32'(i));
    end
    model_mem[8191] = 32'hCAFEF00D;
    for (int i = 0; i < 8192; i++) dut.im[i] = model_mem[i];
    step();
    step();
    rst = 1'b0;
    // Reset state.
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_fault", 32'(resp_fault), 32'h0);
    chk_en = 1'b1;

    // 1: streaming fetch of the ten preloaded words.
    resp_ready = 1'b1;
    obs.delete();
    for (int i = 0; i < 10; i++) issue(16'(16'h3000 + 4*i));
    drain(4);
    check("stream_count", 32'(obs.size()), 32'd10);
    check("stream_first", obs[0].d, 32'h00010203);
    check("stream_last", obs[9].d, 32'h24252627);
    check("stream_fault", 32'(obs[9].f), 32'h0);

    // 2: backpressure with resp_ready low.
    obs.delete();
    resp_ready = 1'b0;
    issue(16'h3000);
    issue(16'h3004);
    req_valid = 1'b1;
    req_addr  = 16'h3008;
    check("stall_ready", 32'(req_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_head", resp_data, 32'h00010203);
      check("stall_ready_hold", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin step(); k++; end
    check("stall_release", 32'(req_ready), 32'h1);
    step();
    drain(4);
    check("stall_count", 32'(obs.size()), 32'd3);
    check("stall_0", obs[0].d, 32'h00010203);
    check("stall_1", obs[1].d, 32'h04050607);
    check("stall_2", obs[2].d, 32'h08090A0B);

    // 3: address faults and segment boundaries.
    obs.delete();
    issue(16'h3002);
    issue(16'h2FFC);
    issue(16'hB000);
    issue(16'hAFFC);
    drain(4);
    check("fault_count", 32'(obs.size()), 32'd4);
    check("fault_misaligned", 32'(obs[0].f), 32'd1);
    check("fault_misaligned_data", obs[0].d, 32'h0);
    check("fault_below", 32'(obs[1].f), 32'd2);
    check("fault_above", 32'(obs[2].f), 32'd2);
    check("fault_above_data", obs[2].d, 32'h0);
    check("last_word_fault", 32'(obs[3].f), 32'd0);
    check("last_word_data", obs[3].d, 32'hCAFEF00D);

    // 4: reset while full.
    resp_ready = 1'b0;
    issue(16'h3000);
    issue(16'h3004);
    check("pre_rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h1);
    rst = 1'b0;
    obs.delete();
    resp_ready = 1'b1;
    issue(16'h3000);
    drain(3);
    check("post_rst_count", 32'(obs.size()), 32'd1);
    check("post_rst_data", obs[0].d, 32'h00010203);

`ifdef IM_LOAD_PORT_EN
    // 5: write and fetch of the same word at one edge.
    obs.delete();
    req_valid = 1'b1; req_addr = 16'h3004;
    wr_en = 1'b1; wr_addr = 16'h3004; wr_data = 32'hDEADBEEF; wr_be = 4'b0011;
    step();
    wr_en = 1'b0; req_valid = 1'b0;
    issue(16'h3004);
    drain(3);
    check("wr_old", obs[0].d, 32'h04050607);
    check("wr_new", obs[1].d, 32'h0405BEEF);
`endif

    // 6: back-to-back requests with resp_ready toggling.
    obs.delete();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      resp_ready = (c % 2 == 0);
      req_valid  = 1'b1;
      req_addr   = 16'(16'h3000 + 4*(k % 10));
      if (req_ready === 1'b1) begin
        sent.push_back(k % 10);
        k++;
      end
      step();
    end
    drain(4);
    check("toggle_count", 32'(obs.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size(); i++) check("toggle_order", obs[i].d, model_mem[sent[i]]);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
